// File: rtl/seed_round_ctrl.sv
// SEED-128 sequencer: load, KeyGenerator wait, NUM_ROUNDS rounds, final swap, then o_Valid held until i_Ack.
// o_Valid rises NUM_ROUNDS+KG_LATENCY+2 edges after fStart is sampled; every output is a flop with no input-to-output path.
module seed_round_ctrl #(
  parameter int NUM_ROUNDS = 16,
  parameter int KG_LATENCY = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       fStart,
  input  logic       fAbort,
  input  logic       i_Ack,
  output logic       fLoad,
  output logic       fKeyStart,
  output logic [3:0] o_Round,
  output logic       fRoundEn,
  output logic       fFinal,
  output logic       o_Valid,
  output logic       fBusy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    ROUND = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [2:0] WAIT_INIT  = (KG_LATENCY > 0) ? 3'(KG_LATENCY - 1) : 3'd0;

  state_t     state;
  logic [2:0] wait_cnt;

  // Outputs are registered alongside the transition so they always match the state being entered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      wait_cnt  <= 3'd0;
      o_Round   <= 4'd0;
      fLoad     <= 1'b0;
      fKeyStart <= 1'b0;
      fRoundEn  <= 1'b0;
      fFinal    <= 1'b0;
      o_Valid   <= 1'b0;
      fBusy     <= 1'b0;
    end else begin
      fLoad     <= 1'b0;
      fKeyStart <= 1'b0;
      fRoundEn  <= 1'b0;
      fFinal    <= 1'b0;
      o_Valid   <= 1'b0;
      fBusy     <= 1'b0;
      if (fAbort) begin
        state    <= IDLE;
        wait_cnt <= 3'd0;
        o_Round  <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            o_Round <= 4'd0;
            if (fStart) begin
              state     <= LOAD;
              wait_cnt  <= WAIT_INIT;
              fLoad     <= 1'b1;
              fKeyStart <= 1'b1;
              fBusy     <= 1'b1;
            end
          end
          LOAD: begin
            fBusy <= 1'b1;
            if (KG_LATENCY > 0) begin
              state <= WAIT;
            end else begin
              state    <= ROUND;
              fRoundEn <= 1'b1;
            end
          end
          WAIT: begin
            fBusy <= 1'b1;
            if (wait_cnt == 3'd0) begin
              state    <= ROUND;
              fRoundEn <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - 3'd1;
            end
          end
          ROUND: begin
            fBusy <= 1'b1;
            if (o_Round == LAST_ROUND) begin
              state  <= FINAL;
              fFinal <= 1'b1;
            end else begin
              o_Round  <= o_Round + 4'd1;
              fRoundEn <= 1'b1;
            end
          end
          FINAL: begin
            state   <= DONE;
            o_Valid <= 1'b1;
          end
          DONE: begin
            if (i_Ack && fStart) begin
              state     <= LOAD;
              o_Round   <= 4'd0;
              wait_cnt  <= WAIT_INIT;
              fLoad     <= 1'b1;
              fKeyStart <= 1'b1;
              fBusy     <= 1'b1;
            end else if (i_Ack) begin
              state   <= IDLE;
              o_Round <= 4'd0;
            end else begin
              o_Valid <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            o_Round  <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seed_round_ctrl.sv
// Bench for seed_round_ctrl: three instances (KG_LATENCY 1, 0, 3) on shared stimulus, checked against a block-position model.
module tb_seed_round_ctrl;

  localparam int NR = 16;
  localparam int KG [3] = '{1, 0, 3};

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic fStart = 1'b0;
  logic fAbort = 1'b0;
  logic i_Ack = 1'b0;

  logic [2:0] fLoad, fKeyStart, fRoundEn, fFinal, o_Valid, fBusy;
  logic [3:0] o_Round [3];

  always #5 Clk = ~Clk;

  seed_round_ctrl #(.NUM_ROUNDS(NR), .KG_LATENCY(1)) dut0 (
    .Clk(Clk), .Rst(Rst), .fStart(fStart), .fAbort(fAbort), .i_Ack(i_Ack),
    .fLoad(fLoad[0]), .fKeyStart(fKeyStart[0]), .o_Round(o_Round[0]), .fRoundEn(fRoundEn[0]),
    .fFinal(fFinal[0]), .o_Valid(o_Valid[0]), .fBusy(fBusy[0]));

  seed_round_ctrl #(.NUM_ROUNDS(NR), .KG_LATENCY(0)) dut1 (
    .Clk(Clk), .Rst(Rst), .fStart(fStart), .fAbort(fAbort), .i_Ack(i_Ack),
    .fLoad(fLoad[1]), .fKeyStart(fKeyStart[1]), .o_Round(o_Round[1]), .fRoundEn(fRoundEn[1]),
    .fFinal(fFinal[1]), .o_Valid(o_Valid[1]), .fBusy(fBusy[1]));

  seed_round_ctrl #(.NUM_ROUNDS(NR), .KG_LATENCY(3)) dut2 (
    .Clk(Clk), .Rst(Rst), .fStart(fStart), .fAbort(fAbort), .i_Ack(i_Ack),
    .fLoad(fLoad[2]), .fKeyStart(fKeyStart[2]), .o_Round(o_Round[2]), .fRoundEn(fRoundEn[2]),
    .fFinal(fFinal[2]), .o_Valid(o_Valid[2]), .fBusy(fBusy[2]));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pos is the cycle index within a block (0 = idle, 1 = load, ... done_pos = waiting for ack).
  int pos [3] = '{0, 0, 0};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int done_pos(input int k);
    return NR + KG[k] + 3;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!Rst || fAbort) pos[k] = 0;
      else if (pos[k] == 0) pos[k] = fStart ? 1 : 0;
      else if (pos[k] == done_pos(k)) begin
        if (i_Ack) pos[k] = fStart ? 1 : 0;
      end else pos[k] = pos[k] + 1;
    end
  endtask

  task automatic check_all(input string ctx);
    for (int k = 0; k < 3; k++) begin
      int p, first_rnd, final_p;
      int e_round;
      p         = pos[k];
      first_rnd = 2 + KG[k];
      final_p   = first_rnd + NR;
      if (p >= first_rnd && p < final_p) e_round = p - first_rnd;
      else if (p >= final_p)             e_round = NR - 1;
      else                               e_round = 0;
      check_val($sformatf("%s.fLoad[%0d]", ctx, k),     fLoad[k],     32'(p == 1));
      check_val($sformatf("%s.fKeyStart[%0d]", ctx, k), fKeyStart[k], 32'(p == 1));
      check_val($sformatf("%s.fRoundEn[%0d]", ctx, k),  fRoundEn[k],  32'(p >= first_rnd && p < final_p));
      check_val($sformatf("%s.fFinal[%0d]", ctx, k),    fFinal[k],    32'(p == final_p));
      check_val($sformatf("%s.o_Valid[%0d]", ctx, k),   o_Valid[k],   32'(p == done_pos(k)));
      check_val($sformatf("%s.fBusy[%0d]", ctx, k),     fBusy[k],     32'(p >= 1 && p <= final_p));
      check_val($sformatf("%s.o_Round[%0d]", ctx, k),   o_Round[k],   32'(e_round));
    end
  endtask

  task automatic step(input string ctx);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(ctx);
    #1;
  endtask

  task automatic async_reset(input string ctx);
    Rst = 1'b0;
    for (int k = 0; k < 3; k++) pos[k] = 0;
    #1;
    check_all(ctx);
    step(ctx);
    Rst = 1'b1;
  endtask

  int lat [3];
  int seen;

  initial begin
    // Reset held for two edges, then released.
    step("reset");
    step("reset");
    Rst = 1'b1;
    step("idle");

    // Nominal run: measure edges from the fStart sample to o_Valid on each instance.
    fStart = 1'b1;
    step("start");
    fStart = 1'b0;
    lat  = '{-1, -1, -1};
    seen = 0;
    for (int j = 1; j <= 40 && seen < 3; j++) begin
      if (j == 6) i_Ack = 1'b1;
      if (j == 7) i_Ack = 1'b0;
      if (j == 10) fStart = 1'b1;
      if (j == 11) fStart = 1'b0;
      step("nominal");
      for (int k = 0; k < 3; k++)
        if (lat[k] < 0 && o_Valid[k] === 1'b1) begin
          lat[k] = j;
          seen++;
        end
    end
    check_val("latency_kg1", lat[0], 19);
    check_val("latency_kg0", lat[1], 18);
    check_val("latency_kg3", lat[2], 21);
    for (int j = 0; j < 4; j++) step("hold_valid");

    // Back-to-back: ack together with start relaunches every instance in DONE.
    i_Ack  = 1'b1;
    fStart = 1'b1;
    step("b2b");
    i_Ack  = 1'b0;
    fStart = 1'b0;
    for (int j = 0; j < 12; j++) step("b2b_run");

    // Abort mid-round, then a clean full run.
    fAbort = 1'b1;
    step("abort");
    fAbort = 1'b0;
    check_val("abort_round", o_Round[0], 0);
    fStart = 1'b1;
    step("restart");
    fStart = 1'b0;
    for (int j = 0; j < 12; j++) step("restart_run");

    // Asynchronous reset between edges while rounds are in flight.
    async_reset("arst");
    for (int j = 0; j < 3; j++) step("arst_idle");

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      fStart = ($urandom_range(0, 3) == 0);
      i_Ack  = ($urandom_range(0, 7) == 0);
      fAbort = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 299) == 0) async_reset("rand_arst");
      else step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
